// File: rtl/seq_alu.sv
// seq_alu: registered signed ALU, sign-extends operands to WIDTH+1 and updates C one edge after an enabled sample
module seq_alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
   input  logic             en,
   output logic [WIDTH:0]   C
);
   logic [WIDTH:0] a, b, f, c_d, c_q;
   assign a = {A[WIDTH-1], A};
   assign b = {B[WIDTH-1], B};
   always_comb begin
      f = '0;
      case (opcode)
         3'b000: f = a + b;
         3'b001: f = a - b;
         3'b010: f = ~a;
         3'b011: f = {{WIDTH{1'b0}}, &B};
         3'b100: f = {{WIDTH{1'b0}}, |A};
         3'b101: f = {{WIDTH{1'b0}}, ^A};
         3'b110: f = a & b;
         3'b111: f = a | b;
         default: f = '0;
      endcase
      c_d = en ? f : c_q;
   end
   always_ff @(posedge clk) begin
      if (rst) c_q <= '0;
      else     c_q <= c_d;
   end
   assign C = c_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu, including pre-edge hold checks for one-cycle latency
module tb_seq_alu;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic [4:0] C;
   int checks = 0;
   int errors = 0;
   logic [4:0] exp_prev = 5'd0;
   bit have_prev = 1'b0;

   seq_alu #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .en(en), .C(C)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int exp);
      logic [4:0] e;
      e = 5'(exp);
      checks++;
      assert (C === e) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, $signed(C), $signed(e));
      end
   endtask

   task automatic step(input string tag, input bit r, input bit e, input int op,
                       input int a, input int b, input int exp);
      rst = r;
      en = e;
      opcode = 3'(op);
      A = 4'(a);
      B = 4'(b);
      #3;
      if (have_prev) chk({tag, "_pre"}, int'($signed(exp_prev)));
      @(posedge clk);
      #1;
      chk(tag, exp);
      exp_prev = 5'(exp);
      have_prev = 1'b1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      step("reset",     1, 1, 0,  7,  7,   0);
      step("add_7_7",   0, 1, 0,  7,  7,  14);
      step("add_min",   0, 1, 0, -8, -8, -16);
      step("sub_max",   0, 1, 1,  7, -8,  15);
      step("sub_min",   0, 1, 1, -8,  7, -15);
      step("not_5",     0, 1, 2,  5,  0,  -6);
      step("rand_m1",   0, 1, 3,  0, -1,   1);
      step("rand_7",    0, 1, 3,  0,  7,   0);
      step("ror_0",     0, 1, 4,  0,  0,   0);
      step("ror_m8",    0, 1, 4, -8,  0,   1);
      step("rxor_7",    0, 1, 5,  7,  0,   1);
      step("and",       0, 1, 6, -1,  6,   6);
      step("or",        0, 1, 7, -8,  1,  -7);
      step("hold_load", 0, 1, 0,  3,  4,   7);
      for (int i = 0; i < 3; i++) step("hold", 0, 0, 1, 1, 1, 7);
      step("hold_en",   0, 1, 1,  1,  1,   0);
      step("b2b_add",   0, 1, 0,  1,  1,   2);
      step("b2b_sub",   0, 1, 1,  5,  2,   3);
      step("b2b_or",    0, 1, 7,  4,  1,   5);
      step("mid_add",   0, 1, 0,  6,  6,  12);
      step("mid_rst",   1, 1, 0,  6,  6,   0);
      step("post_hold", 0, 0, 0,  6,  6,   0);
      step("post_add",  0, 1, 0,  2,  3,   5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, sequential signed ALU.
- Two signed operands and a 3-bit opcode are sampled on each rising clock edge while enabled.
- The result is registered into a one-bit-wider signed output, C, with one cycle of latency.
- Sits behind the ALU interface bundle (A, B, opcode, en, rst, C) that the class-based environment drives and monitors.

Parameters:
- WIDTH, default 4: operand width in bits, signed two's complement. The result is WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- opcode  input  3  operation select.
- en  input  1  when high, C is updated at the next rising edge.
- C  output  WIDTH+1  signed registered result.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset:
  - rst=1 at a rising edge forces C=0 regardless of en, opcode, A or B.
  - Reset has priority over en.
  - Reset asserted mid-stream discards any pending result; the next enabled edge after rst deasserts computes normally.
- Enable:
  - en=1 at a rising edge: C <= f(opcode, A, B) from the values sampled at that edge.
  - en=0: C holds its previous value.
  - No handshake, no ready/valid; back-to-back operations are allowed every cycle.
- Latency: exactly 1 cycle. The result of inputs sampled at edge N is visible after edge N and stable until the next enabled edge.
- Width rule: A and B are sign-extended to WIDTH+1 before arithmetic. All results are WIDTH+1 signed, so add and subtract never overflow.
- Opcode map, with a = sext(A) and b = sext(B):
  - 000 ADD: C = a + b.
  - 001 SUB: C = a - b.
  - 010 NOT: C = ~a (equals -A-1).
  - 011 RAND: C = zero-extended &B (1 if B is all ones, else 0).
  - 100 ROR: C = zero-extended |A.
  - 101 RXOR: C = zero-extended ^A, the parity of A.
  - 110 AND: C = a & b.
  - 111 OR: C = a | b.
- The opcode decode is a full case; no illegal codes exist. X/Z on inputs is not handled specially.
- Range for WIDTH=4:
  - A, B span -8..7.
  - ADD spans -16..14; SUB spans -15..15. Both fit in 5 signed bits.
- The combinational compute path is fully registered. C has no combinational path from the inputs.

Test Plan:
- Reset: rst=1 for one edge with en=1, opcode=000, A=7, B=7 -> C=0. Deassert rst, next edge with the same inputs -> C=14.
- Arithmetic extremes:
  - ADD A=-8, B=-8 -> C=-16.
  - SUB A=7, B=-8 -> C=15.
  - SUB A=-8, B=7 -> C=-15.
  - Each result appears one edge after sampling.
- Logic and reductions:
  - NOT A=5 -> C=-6.
  - RAND B=-1 -> 1; RAND B=7 -> 0.
  - ROR A=0 -> 0; ROR A=-8 -> 1.
  - RXOR A=7 -> 1.
  - AND A=-1, B=6 -> 6.
  - OR A=-8, B=1 -> -7.
- Enable hold: load ADD 3+4 -> C=7, then drop en and drive A=1, B=1, opcode=001 for 3 cycles -> C stays 7. Raise en -> C=0.
- Back-to-back: ADD 1+1, SUB 5-2, OR 4|1 on consecutive edges -> C sequence 2, 3, 5, each one cycle after its inputs.
- Reset mid-operation: with en=1, ADD 6+6 issued, rst=1 on the following edge -> C=0. After rst drops, the next enabled edge computes from the current inputs.
